// File: rtl/alu_seq.sv
// Multi-nibble sequencer that drives a 4-bit ALU slice one nibble per cycle,
// least-significant first, chaining carry and collecting a word result.
module alu_seq #(
   parameter  int unsigned NIBBLES = 4,
   localparam int unsigned W       = 4 * NIBBLES
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_cmd_valid,
   output logic         o_cmd_ready,
   input  logic [2:0]   i_cmd_op,
   input  logic [W-1:0] i_cmd_a,
   input  logic [W-1:0] i_cmd_b,
   output logic         o_res_valid,
   input  logic         i_res_ready,
   output logic [W-1:0] o_res_f,
   output logic         o_res_carry,
   output logic         o_res_zero,
   output logic         o_res_err,
   output logic [3:0]   o_alu_a,
   output logic [3:0]   o_alu_b,
   output logic [3:0]   o_alu_s,
   output logic         o_alu_m,
   output logic         o_alu_crin,
   input  logic [3:0]   i_alu_f,
   input  logic         i_alu_crout
);

   localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_INC  = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_MOVB = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         r_state;
   logic [2:0]     r_op;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [IW-1:0]  r_idx;
   logic           r_carry;
   logic [W-1:0]   r_res_f;
   logic           r_res_zero;
   logic           r_res_err;

   logic [3:0]     w_a;
   logic [3:0]     w_b;
   logic [3:0]     w_s;
   logic           w_m;
   logic           w_crin;
   logic           w_arith;
   logic           w_illegal;
   logic           w_last;
   logic [W-1:0]   w_f_next;

   assign w_arith   = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_INC);
   assign w_illegal = (i_cmd_op > OP_MOVB);
   assign w_last    = (r_idx == IW'(NIBBLES - 1));

   // ALU drive is combinational from state, latched op and nibble index; zero outside RUN.
   always_comb begin
      w_a      = '0;
      w_b      = '0;
      w_s      = '0;
      w_m      = 1'b0;
      w_crin   = 1'b0;
      w_f_next = r_res_f;
      w_f_next[r_idx*4 +: 4] = i_alu_f;
      if (r_state == S_RUN) begin
         w_crin = r_carry;
         case (r_op)
            OP_ADD:  begin w_a = r_a[r_idx*4 +: 4]; w_b = r_b[r_idx*4 +: 4]; w_s = 4'h9; end
            OP_SUB:  begin w_a = r_a[r_idx*4 +: 4]; w_b = r_b[r_idx*4 +: 4]; w_s = 4'h6; end
            OP_INC:  begin w_a = r_a[r_idx*4 +: 4]; w_s = 4'h0; end
            OP_NOR:  begin w_a = r_a[r_idx*4 +: 4]; w_b = r_b[r_idx*4 +: 4]; w_s = 4'h1; w_m = 1'b1; end
            OP_MOVB: begin w_a = r_a[r_idx*4 +: 4]; w_b = r_b[r_idx*4 +: 4]; w_s = 4'hA; w_m = 1'b1; end
            default: w_crin = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_idx      <= '0;
         r_carry    <= 1'b0;
         r_res_f    <= '0;
         r_res_zero <= 1'b0;
         r_res_err  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  r_op       <= i_cmd_op;
                  r_a        <= i_cmd_a;
                  r_b        <= i_cmd_b;
                  r_idx      <= '0;
                  r_res_f    <= '0;
                  r_carry    <= (i_cmd_op == OP_SUB) || (i_cmd_op == OP_INC);
                  r_res_err  <= w_illegal;
                  r_res_zero <= w_illegal;
                  r_state    <= w_illegal ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               r_res_f <= w_f_next;
               r_carry <= w_arith ? i_alu_crout : 1'b0;
               r_idx   <= r_idx + IW'(1);
               if (w_last) begin
                  r_res_zero <= (w_f_next == '0);
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               if (i_res_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_res_valid = (r_state == S_DONE);
   assign o_res_f     = r_res_f;
   assign o_res_carry = r_carry;
   assign o_res_zero  = r_res_zero;
   assign o_res_err   = r_res_err;
   assign o_alu_a     = w_a;
   assign o_alu_b     = w_b;
   assign o_alu_s     = w_s;
   assign o_alu_m     = w_m;
   assign o_alu_crin  = w_crin;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural 4-bit ALU slice.
module tb_alu_seq;

   localparam int unsigned N = 4;
   localparam int unsigned W = 4 * N;

   logic         clk;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_op;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_f;
   logic         res_carry;
   logic         res_zero;
   logic         res_err;
   logic [3:0]   alu_a;
   logic [3:0]   alu_b;
   logic [3:0]   alu_s;
   logic         alu_m;
   logic         alu_crin;
   logic [3:0]   alu_f;
   logic         alu_crout;

   int n_cmp = 0;
   int n_bad = 0;

   alu_seq #(.NIBBLES(N)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_op    (cmd_op),
      .i_cmd_a     (cmd_a),
      .i_cmd_b     (cmd_b),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_f     (res_f),
      .o_res_carry (res_carry),
      .o_res_zero  (res_zero),
      .o_res_err   (res_err),
      .o_alu_a     (alu_a),
      .o_alu_b     (alu_b),
      .o_alu_s     (alu_s),
      .o_alu_m     (alu_m),
      .o_alu_crin  (alu_crin),
      .i_alu_f     (alu_f),
      .i_alu_crout (alu_crout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU slice covering the five select codes the sequencer uses.
   logic [4:0] sum;
   always_comb begin
      sum       = 5'd0;
      alu_f     = 4'd0;
      alu_crout = 1'b0;
      if (!alu_m) begin
         case (alu_s)
            4'h9:    sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_crin};
            4'h6:    sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_crin};
            4'h0:    sum = {1'b0, alu_a} + {4'd0, alu_crin};
            default: sum = 5'd0;
         endcase
         alu_f     = sum[3:0];
         alu_crout = sum[4];
      end else begin
         case (alu_s)
            4'h1:    alu_f = ~(alu_a | alu_b);
            4'hA:    alu_f = alu_b;
            default: alu_f = 4'd0;
         endcase
      end
   end

   // Sample each cycle at negedge until res_valid; lat counts the accept cycle as 1.
   task automatic wait_done(output int lat, output logic [3:0] crins, output int runs,
                            output logic movb_bad, output logic alu_active);
      lat = 1; runs = 0; crins = 4'd0; movb_bad = 1'b0; alu_active = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         lat++;
         if ({alu_a, alu_b, alu_s, alu_m, alu_crin} != 14'd0) alu_active = 1'b1;
         if (res_valid) break;
         if (alu_m !== 1'b1 || alu_s !== 4'hA) movb_bad = 1'b1;
         if (runs < 4) crins[runs] = alu_crin;
         runs++;
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [3:0] crins, output int runs,
                        output logic movb_bad, output logic alu_active);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_done(lat, crins, runs, movb_bad, alu_active);
   endtask

   task automatic release_res();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
      n_cmp++; if (res_f !== 16'h0) begin n_bad++; $display("FAIL reset_res_f got %h want 0000", res_f); end
      n_cmp++; if ({res_carry, res_zero, res_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {res_carry, res_zero, res_err}); end
      n_cmp++; if ({alu_a, alu_b, alu_s, alu_m, alu_crin} !== 14'd0) begin n_bad++; $display("FAIL reset_alu got %h want 0", {alu_a, alu_b, alu_s, alu_m, alu_crin}); end
   endtask

   task automatic test_add();
      int lat; logic [3:0] cr; int runs; logic mb; logic act;
      issue(3'd0, 16'h1234, 16'h0FCF, lat, cr, runs, mb, act);
      n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL add_latency got %0d want 6", lat); end
      n_cmp++; if (res_f !== 16'h2203) begin n_bad++; $display("FAIL add_res_f got %h want 2203", res_f); end
      n_cmp++; if ({res_carry, res_zero, res_err} !== 3'b000) begin n_bad++; $display("FAIL add_flags got %b want 000", {res_carry, res_zero, res_err}); end
      release_res();
      @(negedge clk);
      n_cmp++; if ({cmd_ready, res_valid} !== 2'b10) begin n_bad++; $display("FAIL add_back_idle got %b want 10", {cmd_ready, res_valid}); end
      issue(3'd0, 16'hFFFF, 16'h0001, lat, cr, runs, mb, act);
      n_cmp++; if (res_f !== 16'h0000) begin n_bad++; $display("FAIL addwrap_res_f got %h want 0000", res_f); end
      n_cmp++; if ({res_carry, res_zero, res_err} !== 3'b110) begin n_bad++; $display("FAIL addwrap_flags got %b want 110", {res_carry, res_zero, res_err}); end
      n_cmp++; if (runs != 4 || cr !== 4'b1110) begin n_bad++; $display("FAIL addwrap_crin runs %0d crin(n3..n0) %b want 4 1110", runs, cr); end
      release_res();
   endtask

   task automatic test_sub_inc();
      int lat; logic [3:0] cr; int runs; logic mb; logic act;
      issue(3'd1, 16'h0007, 16'h0005, lat, cr, runs, mb, act);
      n_cmp++; if (res_f !== 16'h0002 || res_carry !== 1'b1 || res_zero !== 1'b0) begin n_bad++; $display("FAIL sub_pos got %h c%b z%b want 0002 c1 z0", res_f, res_carry, res_zero); end
      release_res();
      issue(3'd1, 16'h0005, 16'h0007, lat, cr, runs, mb, act);
      n_cmp++; if (res_f !== 16'hFFFE || res_carry !== 1'b0 || res_zero !== 1'b0) begin n_bad++; $display("FAIL sub_neg got %h c%b z%b want fffe c0 z0", res_f, res_carry, res_zero); end
      release_res();
      issue(3'd2, 16'h00FF, 16'h1234, lat, cr, runs, mb, act);
      n_cmp++; if (res_f !== 16'h0100 || res_carry !== 1'b0 || res_zero !== 1'b0) begin n_bad++; $display("FAIL inc got %h c%b z%b want 0100 c0 z0", res_f, res_carry, res_zero); end
      release_res();
   endtask

   task automatic test_logic();
      int lat; logic [3:0] cr; int runs; logic mb; logic act;
      issue(3'd3, 16'hF0F0, 16'h0FF0, lat, cr, runs, mb, act);
      n_cmp++; if (res_f !== 16'h000F || res_carry !== 1'b0 || res_zero !== 1'b0) begin n_bad++; $display("FAIL nor got %h c%b z%b want 000f c0 z0", res_f, res_carry, res_zero); end
      release_res();
      issue(3'd4, 16'h1111, 16'hBEEF, lat, cr, runs, mb, act);
      n_cmp++; if (res_f !== 16'hBEEF || res_carry !== 1'b0 || res_err !== 1'b0) begin n_bad++; $display("FAIL movb got %h c%b e%b want beef c0 e0", res_f, res_carry, res_err); end
      n_cmp++; if (mb !== 1'b0 || runs != 4) begin n_bad++; $display("FAIL movb_drive bad %b runs %0d want 0 4", mb, runs); end
      release_res();
   endtask

   task automatic test_illegal();
      int lat; logic [3:0] cr; int runs; logic mb; logic act;
      issue(3'd6, 16'h1234, 16'h5678, lat, cr, runs, mb, act);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL illegal_latency got %0d want 2", lat); end
      n_cmp++; if (res_f !== 16'h0 || {res_carry, res_zero, res_err} !== 3'b011) begin n_bad++; $display("FAIL illegal_result got %h cze %b want 0000 011", res_f, {res_carry, res_zero, res_err}); end
      n_cmp++; if (act !== 1'b0) begin n_bad++; $display("FAIL illegal_alu_driven got %b want 0", act); end
      release_res();
   endtask

   task automatic test_back_to_back();
      int lat; logic [3:0] cr; int runs; logic mb; logic act;
      issue(3'd0, 16'h0001, 16'h0001, lat, cr, runs, mb, act);
      n_cmp++; if (res_err !== 1'b0) begin n_bad++; $display("FAIL hold_err_cleared got %b want 0", res_err); end
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 16'h0010; cmd_b = 16'h0020;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (res_valid !== 1'b1 || res_f !== 16'h0002 || cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL hold_cycle%0d valid %b f %h ready %b want 1 0002 0", k, res_valid, res_f, cmd_ready);
         end
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++; if ({cmd_ready, res_valid} !== 2'b10) begin n_bad++; $display("FAIL release_idle got %b want 10", {cmd_ready, res_valid}); end
      @(negedge clk);
      n_cmp++; if ({cmd_ready, res_valid} !== 2'b00) begin n_bad++; $display("FAIL pending_accept got %b want 00", {cmd_ready, res_valid}); end
      cmd_valid = 1'b0;
      wait_done(lat, cr, runs, mb, act);
      n_cmp++; if (res_f !== 16'h0030 || res_valid !== 1'b1) begin n_bad++; $display("FAIL pending_result got %h v%b want 0030 v1", res_f, res_valid); end
      release_res();
   endtask

   task automatic test_reset_mid_run();
      logic seen;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 16'h0007; cmd_b = 16'h0005;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if ({cmd_ready, res_valid} !== 2'b10) begin n_bad++; $display("FAIL midrst_state got %b want 10", {cmd_ready, res_valid}); end
      n_cmp++; if (res_f !== 16'h0 || {res_carry, res_zero, res_err} !== 3'b000) begin n_bad++; $display("FAIL midrst_result got %h cze %b want 0000 000", res_f, {res_carry, res_zero, res_err}); end
      n_cmp++; if ({alu_a, alu_b, alu_s, alu_m, alu_crin} !== 14'd0) begin n_bad++; $display("FAIL midrst_alu got %h want 0", {alu_a, alu_b, alu_s, alu_m, alu_crin}); end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || cmd_ready !== 1'b1) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_result got %b want 0", seen); end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      test_reset();
      rst = 1'b0;
      test_add();
      test_sub_inc();
      test_logic();
      test_illegal();
      test_back_to_back();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-nibble sequencer that drives the 4-bit ALU slice as its initiator. It accepts a word-wide command (opcode plus two operands) over a valid/ready handshake. It then issues one ALU operation per cycle, least-significant nibble first, chaining the carry from each nibble into the next. It collects the ALU result nibbles into a word result with carry, zero and error flags, and holds that result until the consumer accepts it.

## Interface
- NIBBLES, default 4: word width in nibbles; W = 4*NIBBLES; must be ≥ 1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high exactly in IDLE.
- cmd_op  in  3  0=ADD, 1=SUB, 2=INC, 3=NOR, 4=MOVB, 5..7 illegal.
- cmd_a, cmd_b  in  W  operands.
- res_valid  out  1  result held, high exactly in DONE.
- res_ready  in  1  consumer accepts.
- res_f  out  W  result word.
- res_carry  out  1  final carry (arith ops), else 0.
- res_zero  out  1  res_f == 0.
- res_err  out  1  illegal opcode.
- alu_a, alu_b  out  4  current nibble of latched operands.
- alu_s  out  4  ALU function select.
- alu_m  out  1  1 = logic mode.
- alu_crin  out  1  carry into current nibble.
- alu_f  in  4  ALU result nibble.
- alu_crout  in  1  ALU carry out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_valid & cmd_ready latches op, a and b.
  - Clears the nibble index i to 0.
  - Loads the carry register: 1 for SUB/INC, else 0.
  - Goes to RUN; an illegal op goes straight to DONE with res_err=1, res_f=0, res_carry=0, res_zero=1.
- ALU drive per op (combinational from state, op and i):
  - ADD: m=0, s=9, a=a[i], b=b[i].
  - SUB: m=0, s=6 (a + ~b + crin).
  - INC: m=0, s=0, b=0.
  - NOR: m=1, s=1.
  - MOVB: m=1, s=A (result = b).
- alu_crin = carry register during RUN.
- Outside RUN, all ALU outputs are 0. The sequencer never presents a select outside the five listed codes, because the ALU result is undefined for them.
- RUN, each cycle:
  - res_f nibble i <= alu_f.
  - carry <= alu_crout for arithmetic ops; for logic ops carry is held at 0.
  - i <= i+1.
  - When i == NIBBLES-1, go to DONE.
- DONE: outputs are stable while res_valid=1. When res_ready=1, return to IDLE.
- Flags:
  - res_carry = final carry register.
  - SUB carry=1 means no borrow (a ≥ b unsigned).
  - res_zero is computed from the registered res_f.
- A new command is accepted only in IDLE. cmd_valid in RUN/DONE is ignored and must be held by the source.
- res_f is cleared at command accept, so no stale nibbles remain from the previous result.

## Timing
- Reset (async, immediate): state=IDLE, cmd_ready=1, res_valid=0, res_f=0, res_carry=0, res_zero=0, res_err=0, all alu_* outputs 0, i=0, carry=0.
- Reset mid-RUN or mid-DONE aborts the command. The result is discarded and no res_valid is produced.
- Accept at edge T: RUN occupies cycles T+1..T+NIBBLES, with nibble i driven to the ALU in cycle T+1+i.
- res_valid rises after edge T+NIBBLES+1 and stays high until the first edge where res_ready=1.
- Illegal op: res_valid is high after edge T+1.
- Minimum spacing between accepts is NIBBLES+2 cycles (one cycle back in IDLE after result accept).
- res_ready sampled high in the same cycle res_valid first rises completes the transfer at that edge.
- The ALU path is combinational: alu_f/alu_crout are sampled in the same cycle the nibble is driven.
- The carry chain wraps at the top nibble: carry out of nibble NIBBLES-1 becomes res_carry and is never fed back.

## Test plan
- ADD 0x1234 + 0x0FCF -> res_f=0x2203, carry=0, zero=0, res_valid 6 cycles after accept.
- ADD 0xFFFF + 0x0001 -> res_f=0x0000, carry=1, zero=1; the alu_crin sequence across the four nibbles is 0,1,1,1.
- SUB 0x0007 − 0x0005 -> 0x0002, carry=1; SUB 0x0005 − 0x0007 -> 0xFFFE, carry=0; INC 0x00FF -> 0x0100, carry=0.
- NOR 0xF0F0, 0x0FF0 -> 0x000F, carry=0; MOVB b=0xBEEF -> 0xBEEF, with alu_m=1 and alu_s=A each RUN cycle.
- Op=6 -> res_err=1, res_f=0, zero=1, res_valid 2 cycles after accept; the ALU is never driven.
- Handshake/reset:
  - Hold res_ready low 3 cycles: outputs stable, cmd_ready=0, a second cmd_valid is not accepted.
  - Release res_ready: the pending command is accepted one cycle later.
  - Assert rst in the 2nd RUN cycle: state returns to IDLE immediately, all outputs at reset values.
